// File: rtl/moonbase_xbus_master.sv
`default_nettype none
// ============================================================================
//  Module   : moonbase_xbus_master
//  Purpose  : Nibble-serial external bus master for the moonbase 8-bit pad
//             interface. Turns single-word read/write requests into the
//             address-latch / SRAM / device pin sequence.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             req_valid/req_ready - request handshake
//             req_write, req_dev  - 1 = write / 1 = device space
//             req_addr, req_wdata - word address and write data
//             rsp_valid           - one-cycle completion pulse
//             rsp_rdata           - read data (0 on write completions)
//             bus_out             - pads {strobe, idx, payload[5:0]}
//             bus_in              - pads [3:0] SRAM nibble, [5:4] device bits
//  Revision : 1.0 - initial release
// ============================================================================
module moonbase_xbus_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_dev,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        bus_out,
  input  logic [5:0]        bus_in
);

  localparam int c_A = (ADDR_W > 6) ? 2 : 1;
  localparam int c_D = DATA_W / 4;

  localparam logic [2:0] c_A_LAST = 3'(c_A - 1);
  localparam logic [2:0] c_W_LAST = 3'(WAIT_STATES - 1);
  localparam logic [2:0] c_D_LAST = 3'(c_D - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                r_write;
  logic                r_dev;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_accept;
  logic [3:0]          w_in_nib;
  logic [DATA_W+3:0]   w_shift;
  logic [11:0]         w_addr_ext;
  logic [7:0]          w_wdata_ext;
  logic [3:0]          w_wnib;
  logic                w_we_ram_n;
  logic                w_we_dev_n;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  // Device space only drives two bits; they land in the low end of the nibble.
  assign w_in_nib    = r_dev ? {2'b00, bus_in[5:4]} : bus_in[3:0];
  assign w_shift     = {r_rdata, w_in_nib};
  assign w_addr_ext  = 12'(r_addr);
  assign w_wdata_ext = 8'(r_wdata);
  // Most-significant nibble goes first; an 8-bit word uses the high nibble
  // on data cycle 0, a 4-bit word only ever has the low nibble.
  assign w_wnib      = (c_D == 2 && !r_cnt[0]) ? w_wdata_ext[7:4] : w_wdata_ext[3:0];
  assign w_we_ram_n  = !(r_write && !r_dev);
  assign w_we_dev_n  = !(r_write && r_dev);
  assign rsp_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_dev   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_dev   <= req_dev;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        // Cleared here so write completions report zero read data.
        r_rdata <= '0;
      end else if (r_state == S_DATA && !r_write) begin
        r_rdata <= w_shift[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    bus_out     = 8'h80;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = S_ADDR;
          w_cnt_nxt   = 3'd0;
        end
      end
      S_ADDR: begin
        bus_out = {1'b1, r_cnt[0], (r_cnt[0] ? w_addr_ext[11:6] : w_addr_ext[5:0])};
        if (r_cnt == c_A_LAST) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_WAIT: begin
        bus_out = 8'h30;
        if (r_cnt == c_W_LAST) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DATA: begin
        bus_out = {1'b0, r_cnt[0], w_we_ram_n, w_we_dev_n, (r_write ? w_wnib : 4'h0)};
        if (r_cnt == c_D_LAST) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
    // Reset overrides the pads immediately so no write strobe can escape
    // during the reset cycle.
    if (reset) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      bus_out   = 8'h80;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_moonbase_xbus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_moonbase_xbus_master
//  Purpose  : Directed self-checking bench for moonbase_xbus_master, with a
//             default-parameter instance and a narrow/wait-state instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_moonbase_xbus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_dev = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  bus_out;
  logic [5:0]  bus_in = '0;

  logic        p_req_valid = 1'b0;
  logic        p_req_ready;
  logic        p_req_write = 1'b0;
  logic        p_req_dev = 1'b0;
  logic [5:0]  p_req_addr = '0;
  logic [3:0]  p_req_wdata = '0;
  logic        p_rsp_valid;
  logic [3:0]  p_rsp_rdata;
  logic [7:0]  p_bus_out;
  logic [5:0]  p_bus_in = '0;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  moonbase_xbus_master #(.ADDR_W(12), .DATA_W(8), .WAIT_STATES(0)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_out(bus_out), .bus_in(bus_in)
  );

  moonbase_xbus_master #(.ADDR_W(6), .DATA_W(4), .WAIT_STATES(3)) u_dut_p (
    .clk(clk), .reset(reset),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_write(p_req_write),
    .req_dev(p_req_dev), .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata),
    .bus_out(p_bus_out), .bus_in(p_bus_in)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Present a request in IDLE, take the accept edge, then scramble the
  // request fields so the held copies are exercised.
  task automatic issue(input logic w, input logic d, input logic [11:0] a,
                       input logic [7:0] wd);
    req_write = w; req_dev = d; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_write = ~w; req_dev = ~d; req_addr = ~a; req_wdata = ~wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (bus_out !== 8'h80) begin errors++; $display("FAIL rst_bus actual=%h required=80", bus_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready actual=%b required=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp actual=%b required=0", rsp_valid); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after actual=%b required=1", req_ready); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata actual=%h required=00", rsp_rdata); end
    checks++; if (p_req_ready !== 1'b1) begin errors++; $display("FAIL rst_p_ready actual=%b required=1", p_req_ready); end
  endtask

  task automatic test_sram_read();
    bus_in = 6'h3F;
    issue(1'b0, 1'b0, 12'hABC, 8'h00);
    checks++; if (bus_out !== 8'hBC) begin errors++; $display("FAIL rd_addr0 actual=%h required=BC", bus_out); end
    step();
    checks++; if (bus_out !== 8'hEA) begin errors++; $display("FAIL rd_addr1 actual=%h required=EA", bus_out); end
    step();
    checks++; if (bus_out !== 8'h30) begin errors++; $display("FAIL rd_data0 actual=%h required=30", bus_out); end
    bus_in = 6'h05;
    step();
    checks++; if (bus_out !== 8'h70) begin errors++; $display("FAIL rd_data1 actual=%h required=70", bus_out); end
    bus_in = 6'h0A;
    step();
    bus_in = 6'h3F;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp actual=%b required=1", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h5A) begin errors++; $display("FAIL rd_rdata actual=%h required=5A", rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_resp actual=%b required=0", req_ready); end
    checks++; if (bus_out !== 8'h80) begin errors++; $display("FAIL rd_bus_resp actual=%h required=80", bus_out); end
    step();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_idle actual=%b%b required=10", req_ready, rsp_valid); end
  endtask

  task automatic test_sram_write();
    issue(1'b1, 1'b0, 12'h041, 8'hC3);
    checks++; if (bus_out !== 8'h81) begin errors++; $display("FAIL wr_addr0 actual=%h required=81", bus_out); end
    step();
    checks++; if (bus_out !== 8'hC1) begin errors++; $display("FAIL wr_addr1 actual=%h required=C1", bus_out); end
    step();
    checks++; if (bus_out !== 8'h1C) begin errors++; $display("FAIL wr_data0 actual=%h required=1C", bus_out); end
    step();
    checks++; if (bus_out !== 8'h53) begin errors++; $display("FAIL wr_data1 actual=%h required=53", bus_out); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp actual=%b required=1", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata actual=%h required=00", rsp_rdata); end
    step();
  endtask

  task automatic test_dev_write();
    issue(1'b1, 1'b1, 12'h041, 8'hC3);
    step();
    step();
    checks++; if (bus_out !== 8'h2C) begin errors++; $display("FAIL dw_data0 actual=%h required=2C", bus_out); end
    step();
    checks++; if (bus_out !== 8'h63) begin errors++; $display("FAIL dw_data1 actual=%h required=63", bus_out); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dw_rsp actual=%b required=1", rsp_valid); end
    step();
  endtask

  task automatic test_dev_read();
    issue(1'b0, 1'b1, 12'h041, 8'h00);
    step();
    step();
    checks++; if (bus_out !== 8'h30) begin errors++; $display("FAIL dr_data0 actual=%h required=30", bus_out); end
    bus_in = 6'h2F;
    step();
    bus_in = 6'h15;
    step();
    bus_in = 6'h00;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dr_rsp actual=%b required=1", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h21) begin errors++; $display("FAIL dr_rdata actual=%h required=21", rsp_rdata); end
    step();
  endtask

  task automatic test_wait_states();
    logic [7:0] exp_bus [5];
    exp_bus = '{8'h95, 8'h30, 8'h30, 8'h30, 8'h30};
    p_req_write = 1'b0; p_req_dev = 1'b0; p_req_addr = 6'h15; p_req_valid = 1'b1;
    step();
    p_req_valid = 1'b0; p_req_addr = 6'h2A;
    for (int i = 0; i < 5; i++) begin
      checks++; if (p_bus_out !== exp_bus[i]) begin errors++; $display("FAIL ws_bus%0d actual=%h required=%h", i + 1, p_bus_out, exp_bus[i]); end
      checks++; if (p_rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_early_rsp%0d actual=%b required=0", i + 1, p_rsp_valid); end
      p_bus_in = (i == 4) ? 6'h07 : 6'h0C;
      step();
    end
    p_bus_in = 6'h00;
    checks++; if (p_rsp_valid !== 1'b1) begin errors++; $display("FAIL ws_rsp actual=%b required=1", p_rsp_valid); end
    checks++; if (p_rsp_rdata !== 4'h7) begin errors++; $display("FAIL ws_rdata actual=%h required=7", p_rsp_rdata); end
    step();
  endtask

  task automatic test_reset_abort();
    logic bad_we;
    logic saw_rsp;
    bad_we = 1'b0;
    saw_rsp = 1'b0;
    issue(1'b1, 1'b0, 12'h041, 8'hC3);
    step();
    reset = 1'b1;
    #1;
    checks++; if (bus_out !== 8'h80) begin errors++; $display("FAIL ab_bus actual=%h required=80", bus_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ab_ready actual=%b required=0", req_ready); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ab_ready_after actual=%b required=1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (!bus_out[7] && (!bus_out[5] || !bus_out[4])) bad_we = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
      step();
    end
    checks++; if (bad_we !== 1'b0) begin errors++; $display("FAIL ab_we actual=%b required=0", bad_we); end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL ab_rsp actual=%b required=0", saw_rsp); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL ab_rdata actual=%h required=00", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [3];
    logic [7:0]  exp_a0 [3];
    logic [7:0]  exp_a1 [3];
    logic [7:0]  exp_rd [3];
    int t_prev;
    int t_acc;
    int budget;
    addrs  = '{12'h123, 12'h456, 12'h789};
    exp_a0 = '{8'hA3, 8'h96, 8'h89};
    exp_a1 = '{8'hC4, 8'hD1, 8'hDE};
    exp_rd = '{8'h11, 8'h22, 8'h33};
    t_prev = 0;
    req_write = 1'b0; req_dev = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = addrs[k];
      bus_in = 6'(k + 1);
      budget = 0;
      while (!req_ready && budget < 10) begin
        step();
        budget++;
      end
      if (!req_ready) begin
        checks++; errors++;
        $display("FAIL b2b_ready_timeout%0d actual=0 required=1", k);
      end
      t_acc = cyc_n;
      step();
      req_addr = ~addrs[(k + 1) % 3];
      if (k > 0) begin
        checks++; if (t_acc - t_prev !== 6) begin errors++; $display("FAIL b2b_period%0d actual=%0d required=6", k, t_acc - t_prev); end
      end
      t_prev = t_acc;
      checks++; if (bus_out !== exp_a0[k]) begin errors++; $display("FAIL b2b_addr0_%0d actual=%h required=%h", k, bus_out, exp_a0[k]); end
      step();
      checks++; if (bus_out !== exp_a1[k]) begin errors++; $display("FAIL b2b_addr1_%0d actual=%h required=%h", k, bus_out, exp_a1[k]); end
      step();
      step();
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd[k]) begin errors++; $display("FAIL b2b_rsp%0d actual=%b/%h required=1/%h", k, rsp_valid, rsp_rdata, exp_rd[k]); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp%0d actual=%b required=0", k, req_ready); end
    end
    req_valid = 1'b0;
    bus_in = 6'h00;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_dev_write();
    test_dev_read();
    test_wait_states();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
